// File: rtl/drain_pkg.sv
// Shared definitions for the packet drain engine.
// Action word field positions and the drain FSM state encoding.
package drain_pkg;

  localparam int ACT_DROP_BIT = 0;
  localparam int ACT_PORT_LSB = 8;
  localparam int ACT_PORT_W   = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XFER    = 2'd1,
    DISCARD = 2'd2
  } state_t;

endpackage

// File: rtl/action_credit_fifo.sv
// Synchronous FIFO holding action words, one per drain credit.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   push, din       write one word (discarded when full with no pop)
//   pop, dout       read head (dout is the current head, fall-through)
//   full, empty     occupancy flags
//   overflow        sticky: a push was discarded because the FIFO was full
module action_credit_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // A push into a full FIFO is still accepted when a pop frees a slot
  // in the same cycle; pointers wrap naturally because DEPTH is 2^AW.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !do_push) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/pkt_drain_engine.sv
// Drains one packet from the packet FIFO per allow_drain credit, either
// forwarding it on the egress stream (tagged with the action's port) or
// discarding it when the action's drop bit is set.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   allow_drain,action_in credit pulse and its action word
//   pf_empty/pf_data/pf_last, pf_rd_en   packet FIFO read port (FWFT)
//   m_valid/m_ready/m_data/m_last/m_port egress stream
//   fwd_cnt, drop_cnt     wrapping packet counters
//   err_overflow          sticky credit-queue overflow
//   fsm_state             current FSM state, for observation
// Egress handshake: a beat transfers on a rising clk edge where m_valid and
// m_ready are both high; once m_valid rises, m_valid/m_data/m_last hold
// until that transfer because the FIFO head is only popped on acceptance.
module pkt_drain_engine
  import drain_pkg::*;
#(
  parameter int ACTION_W  = 64,
  parameter int DATA_W    = 64,
  parameter int ACT_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  allow_drain,
  input  logic [ACTION_W-1:0]   action_in,
  input  logic                  pf_empty,
  input  logic [DATA_W-1:0]     pf_data,
  input  logic                  pf_last,
  output logic                  pf_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_W-1:0]     m_data,
  output logic                  m_last,
  output logic [ACT_PORT_W-1:0] m_port,
  output logic [31:0]           fwd_cnt,
  output logic [31:0]           drop_cnt,
  output logic                  err_overflow,
  output state_t                fsm_state
);

  state_t              state;
  state_t              state_nxt;
  logic [ACTION_W-1:0] cur_act;
  logic [ACTION_W-1:0] q_dout;
  logic                q_full;
  logic                q_empty;
  logic                act_pop;
  logic                eop;
  logic                fwd_inc;
  logic                drop_inc;
  logic                unused_act_bits;

  action_credit_fifo #(
    .DEPTH (ACT_DEPTH),
    .WIDTH (ACTION_W)
  ) u_credit_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (allow_drain),
    .din      (action_in),
    .pop      (act_pop),
    .dout     (q_dout),
    .full     (q_full),
    .empty    (q_empty),
    .overflow (err_overflow)
  );

  assign m_data    = pf_data;
  assign m_port    = cur_act[ACT_PORT_LSB +: ACT_PORT_W];
  assign fsm_state = state;
  // Only the port field of the latched action is used after load.
  assign unused_act_bits = ^{cur_act, q_full};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cur_act  <= '0;
      fwd_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (act_pop)  cur_act  <= q_dout;
      if (fwd_inc)  fwd_cnt  <= fwd_cnt + 32'd1;
      if (drop_inc) drop_cnt <= drop_cnt + 32'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    act_pop   = 1'b0;
    m_valid   = 1'b0;
    m_last    = 1'b0;
    pf_rd_en  = 1'b0;
    eop       = 1'b0;
    fwd_inc   = 1'b0;
    drop_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (!q_empty) begin
          act_pop   = 1'b1;
          state_nxt = q_dout[ACT_DROP_BIT] ? DISCARD : XFER;
        end
      end
      XFER: begin
        m_valid  = ~pf_empty;
        m_last   = pf_last;
        pf_rd_en = m_valid & m_ready;
        fwd_inc  = pf_rd_en & pf_last;
        eop      = fwd_inc;
      end
      DISCARD: begin
        pf_rd_en = ~pf_empty;
        drop_inc = pf_rd_en & pf_last;
        eop      = drop_inc;
      end
      default: state_nxt = IDLE;
    endcase
    // Chain straight into the next queued action at end of packet so
    // back-to-back packets see no idle cycle.
    if (eop) begin
      if (!q_empty) begin
        act_pop   = 1'b1;
        state_nxt = q_dout[ACT_DROP_BIT] ? DISCARD : XFER;
      end else begin
        state_nxt = IDLE;
      end
    end
  end

endmodule

// File: tb/tb_pkt_drain_engine.sv
// Directed bench for pkt_drain_engine with a packet-FIFO model and an
// expected-beat scoreboard checked on every accepted egress beat.
module tb_pkt_drain_engine;
  import drain_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        allow_drain = 1'b0;
  logic [63:0] action_in = '0;
  logic        pf_empty;
  logic [63:0] pf_data;
  logic        pf_last;
  logic        pf_rd_en;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [63:0] m_data;
  logic        m_last;
  logic [7:0]  m_port;
  logic [31:0] fwd_cnt;
  logic [31:0] drop_cnt;
  logic        err_overflow;
  state_t      fsm_state;

  pkt_drain_engine #(.ACTION_W(64), .DATA_W(64), .ACT_DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .allow_drain  (allow_drain),
    .action_in    (action_in),
    .pf_empty     (pf_empty),
    .pf_data      (pf_data),
    .pf_last      (pf_last),
    .pf_rd_en     (pf_rd_en),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_last       (m_last),
    .m_port       (m_port),
    .fwd_cnt      (fwd_cnt),
    .drop_cnt     (drop_cnt),
    .err_overflow (err_overflow),
    .fsm_state    (fsm_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- packet FIFO model (first-word fall-through) ----------------
  logic [63:0] pf_mem_d [64];
  logic        pf_mem_l [64];
  int          pf_wr = 0;
  int          pf_rd = 0;
  int          pf_pops = 0;
  logic        pf_hold = 1'b0;

  assign pf_empty = pf_hold || (pf_rd == pf_wr);
  assign pf_data  = pf_mem_d[pf_rd[5:0]];
  assign pf_last  = pf_mem_l[pf_rd[5:0]];

  always @(posedge clk) begin
    if (!rst_n) begin
      pf_rd <= pf_wr;
    end else if (pf_rd_en && !pf_empty) begin
      pf_rd   <= pf_rd + 1;
      pf_pops <= pf_pops + 1;
    end
  end

  // ---------------- scoreboard: {port, last, data} ----------------
  logic [72:0] exp_q[$];
  int          beats_seen = 0;
  logic        in_drop = 1'b0;

  always @(negedge clk) begin
    logic [72:0] e;
    if (rst_n && in_drop) chk("drop_no_valid", m_valid, 0);
    if (rst_n && m_valid && m_ready) begin
      chk("beat_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("beat_data", m_data, e[63:0]);
        chk("beat_last", m_last, e[64]);
        chk("beat_port", m_port, e[72:65]);
      end
      beats_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic add_pkt(input int n, input logic [7:0] port, input logic fwd);
    logic [63:0] d;
    for (int i = 0; i < n; i++) begin
      d = {$urandom, $urandom};
      pf_mem_d[pf_wr[5:0]] = d;
      pf_mem_l[pf_wr[5:0]] = (i == n - 1);
      pf_wr = pf_wr + 1;
      if (fwd) exp_q.push_back({port, (i == n - 1), d});
    end
  endtask

  task automatic credit(input logic [7:0] port, input logic drop);
    logic [63:0] a;
    @(posedge clk); #2;
    a = {$urandom, $urandom};
    a[15:8] = port;
    a[0] = drop;
    allow_drain = 1'b1;
    action_in = a;
  endtask

  task automatic idle_in();
    @(posedge clk); #2;
    allow_drain = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && pf_rd == pf_wr) break;
    end
    chk("drain_done", (exp_q.size() == 0 && pf_rd == pf_wr), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [63:0] held;
    int          pops0;
    int          b0;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_port", m_port, 0);
    chk("rst_pf_rd_en", pf_rd_en, 0);
    chk("rst_fwd_cnt", fwd_cnt, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_overflow", err_overflow, 0);
    chk("rst_state", fsm_state, IDLE);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // 1: single forwarded 3-beat packet, pulse-to-beat latency
    add_pkt(3, 8'h05, 1'b1);
    credit(8'h05, 1'b0);
    idle_in();
    @(negedge clk);
    chk("lat_no_valid_n", m_valid, 0);
    @(negedge clk);
    chk("lat_valid_n1", m_valid, 1);
    chk("t1_port", m_port, 8'h05);
    wait_drain(20);
    chk("t1_fwd_cnt", fwd_cnt, 1);
    chk("t1_state_idle", fsm_state, IDLE);

    // 2: dropped 4-beat packet
    in_drop = 1'b1;
    pops0 = pf_pops;
    add_pkt(4, 8'h33, 1'b0);
    credit(8'h33, 1'b1);
    idle_in();
    wait_drain(20);
    @(negedge clk);
    in_drop = 1'b0;
    chk("t2_pops", pf_pops - pops0, 4);
    chk("t2_drop_cnt", drop_cnt, 1);
    chk("t2_fwd_cnt", fwd_cnt, 1);

    // 3: back-to-back credits, three 2-beat packets, no gap
    add_pkt(2, 8'h01, 1'b1);
    add_pkt(2, 8'h02, 1'b1);
    add_pkt(2, 8'h03, 1'b1);
    credit(8'h01, 1'b0);
    credit(8'h02, 1'b0);
    credit(8'h03, 1'b0);
    @(negedge clk);
    chk("b2b_beat0", m_valid, 1);
    idle_in();
    @(negedge clk);
    chk("b2b_beat1", m_valid, 1);
    for (int i = 2; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("b2b_beat%0d", i), m_valid, 1);
    end
    @(negedge clk);
    chk("b2b_after", m_valid, 0);
    wait_drain(20);
    chk("t3_fwd_cnt", fwd_cnt, 4);

    // 4: m_ready 1,0,0,1 mid-packet
    add_pkt(4, 8'h07, 1'b1);
    credit(8'h07, 1'b0);
    idle_in();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_valid) break;
    end
    chk("t4_valid_seen", m_valid, 1);
    @(posedge clk); #2;
    m_ready = 1'b0;
    @(negedge clk);
    held = m_data;
    chk("stall_head", m_data, exp_q[0][63:0]);
    @(posedge clk); #2;
    @(negedge clk);
    chk("stall_hold_data", m_data, held);
    chk("stall_hold_valid", m_valid, 1);
    chk("stall_no_pop", pf_rd_en, 0);
    @(posedge clk); #2;
    m_ready = 1'b1;
    wait_drain(20);
    chk("t4_fwd_cnt", fwd_cnt, 5);

    // 5: overflow while the FSM is stalled on an empty packet FIFO
    pf_hold = 1'b1;
    add_pkt(3, 8'h0A, 1'b1);
    credit(8'h0A, 1'b0);
    idle_in();
    repeat (2) @(negedge clk);
    chk("t5_state_xfer", fsm_state, XFER);
    for (int k = 0; k < 4; k++) credit(8'h10 + 8'(k), 1'b0);
    idle_in();
    @(negedge clk);
    chk("t5_no_ovf_at_4", err_overflow, 0);
    credit(8'h20, 1'b0);
    idle_in();
    @(negedge clk);
    chk("t5_ovf_set", err_overflow, 1);
    repeat (4) @(negedge clk);
    chk("t5_ovf_sticky", err_overflow, 1);

    // 6: reset in the middle of the stalled packet
    @(posedge clk); #2;
    pf_hold = 1'b0;
    b0 = beats_seen;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (beats_seen >= b0 + 2) break;
    end
    chk("t6_two_beats", beats_seen - b0, 2);
    @(posedge clk); #2;
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_m_last", m_last, 0);
    chk("mid_rst_m_port", m_port, 0);
    chk("mid_rst_pf_rd_en", pf_rd_en, 0);
    chk("mid_rst_fwd_cnt", fwd_cnt, 0);
    chk("mid_rst_drop_cnt", drop_cnt, 0);
    chk("mid_rst_overflow", err_overflow, 0);
    chk("mid_rst_state", fsm_state, IDLE);
    @(posedge clk); #2;
    rst_n = 1'b1;
    // Data waits in the packet FIFO; an empty credit queue leaves it alone.
    add_pkt(2, 8'h44, 1'b1);
    repeat (3) @(negedge clk);
    chk("post_rst_q_empty_valid", m_valid, 0);
    chk("post_rst_q_empty_state", fsm_state, IDLE);
    credit(8'h44, 1'b0);
    idle_in();
    wait_drain(20);
    chk("post_rst_fwd_cnt", fwd_cnt, 1);
    chk("post_rst_port", m_port, 8'h44);

    chk("final_exp_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
